// File: rtl/veldt_rvfi_pkg.sv
// Shared types and constants for the veldt RVFI transmit path.
// The retirement struct is fixed at the 32-bit RVFI word width.
package veldt_rvfi_pkg;

  localparam int RVFI_XLEN = 32;
  localparam int RVFI_MASK_W = RVFI_XLEN / 8;

  localparam logic [1:0] RVFI_MODE_M = 2'b11;
  localparam logic [1:0] RVFI_IXL_32 = 2'b01;

  typedef enum logic [1:0] {
    ST_FIRST  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } rvfi_tx_state_t;

  typedef struct packed {
    logic [31:0]            insn;
    logic                   trap;
    logic [RVFI_XLEN-1:0]   pc;
    logic [RVFI_XLEN-1:0]   next_pc;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [4:0]             rd_addr;
    logic [RVFI_XLEN-1:0]   rs1_data;
    logic [RVFI_XLEN-1:0]   rs2_data;
    logic [RVFI_XLEN-1:0]   rd_data;
    logic [RVFI_XLEN-1:0]   mem_addr;
    logic [RVFI_XLEN-1:0]   mem_rdata;
    logic [RVFI_XLEN-1:0]   mem_wdata;
    logic [RVFI_MASK_W-1:0] mem_rmask;
    logic [RVFI_MASK_W-1:0] mem_wmask;
  } rvfi_ret_t;

  // x0 is hardwired to zero, so any write value reported for it is meaningless.
  function automatic logic [RVFI_XLEN-1:0] mask_rd_data(input logic [4:0] addr,
                                                        input logic [RVFI_XLEN-1:0] data);
    return (addr == 5'd0) ? '0 : data;
  endfunction

endpackage

// File: rtl/veldt_rvfi_pcchk.sv
// PC-chain continuity checker: remembers the last emitted next_pc and raises a
// sticky pc_gap when a checked retirement does not start there.
module veldt_rvfi_pcchk
  import veldt_rvfi_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_en,
  input  logic            check_en,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] next_pc,
  output logic            pc_gap
);

  logic [XLEN-1:0] exp_pc_reg;
  logic            pc_gap_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_pc_reg <= '0;
      pc_gap_reg <= 1'b0;
    end else begin
      if (load_en) begin
        exp_pc_reg <= next_pc;
      end
      if (check_en && (pc != exp_pc_reg)) begin
        pc_gap_reg <= 1'b1;
      end
    end
  end

  assign pc_gap = pc_gap_reg;

endmodule

// File: rtl/veldt_rvfi_tx.sv
// RVFI transmit stage: registers retirements into in-order RVFI packets.
// Memory fields are only forwarded when VELDT_RVFI_MEM_EN is defined.
module veldt_rvfi_tx
  import veldt_rvfi_pkg::*;
#(
  parameter int XLEN = RVFI_XLEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ret_valid,
  input  logic [31:0]       ret_insn,
  input  logic              ret_trap,
  input  logic [XLEN-1:0]   ret_pc,
  input  logic [XLEN-1:0]   ret_next_pc,
  input  logic [4:0]        ret_rs1_addr,
  input  logic [4:0]        ret_rs2_addr,
  input  logic [4:0]        ret_rd_addr,
  input  logic [XLEN-1:0]   ret_rs1_data,
  input  logic [XLEN-1:0]   ret_rs2_data,
  input  logic [XLEN-1:0]   ret_rd_data,
  input  logic [XLEN-1:0]   ret_mem_addr,
  input  logic [XLEN-1:0]   ret_mem_rdata,
  input  logic [XLEN-1:0]   ret_mem_wdata,
  input  logic [XLEN/8-1:0] ret_mem_rmask,
  input  logic [XLEN/8-1:0] ret_mem_wmask,
  input  logic              halt_req,
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [31:0]       rvfi_insn,
  output logic              rvfi_trap,
  output logic              rvfi_halt,
  output logic              rvfi_intr,
  output logic [1:0]        rvfi_mode,
  output logic [1:0]        rvfi_ixl,
  output logic [4:0]        rvfi_rs1_addr,
  output logic [4:0]        rvfi_rs2_addr,
  output logic [XLEN-1:0]   rvfi_rs1_rdata,
  output logic [XLEN-1:0]   rvfi_rs2_rdata,
  output logic [4:0]        rvfi_rd_addr,
  output logic [XLEN-1:0]   rvfi_rd_wdata,
  output logic [XLEN-1:0]   rvfi_pc_rdata,
  output logic [XLEN-1:0]   rvfi_pc_wdata,
  output logic [XLEN-1:0]   rvfi_mem_addr,
  output logic [XLEN/8-1:0] rvfi_mem_rmask,
  output logic [XLEN/8-1:0] rvfi_mem_wmask,
  output logic [XLEN-1:0]   rvfi_mem_rdata,
  output logic [XLEN-1:0]   rvfi_mem_wdata,
  output logic              pc_gap,
  output logic              halted
);

  rvfi_tx_state_t state_reg;
  rvfi_ret_t      ret_next;
  rvfi_ret_t      pkt_reg;
  logic           valid_reg;
  logic [63:0]    order_reg;
  logic [63:0]    order_cnt_reg;
  logic           halt_reg;
  logic           intr_reg;
  logic           intr_pend_reg;
  logic           emit;

  assign emit = ret_valid && (state_reg != ST_HALTED);

  always_comb begin
    ret_next          = '0;
    ret_next.insn     = ret_insn;
    ret_next.trap     = ret_trap;
    ret_next.pc       = ret_pc;
    ret_next.next_pc  = ret_next_pc;
    ret_next.rs1_addr = ret_rs1_addr;
    ret_next.rs2_addr = ret_rs2_addr;
    ret_next.rd_addr  = ret_rd_addr;
    ret_next.rs1_data = ret_rs1_data;
    ret_next.rs2_data = ret_rs2_data;
    ret_next.rd_data  = mask_rd_data(ret_rd_addr, ret_rd_data);
`ifdef VELDT_RVFI_MEM_EN
    ret_next.mem_addr  = ret_mem_addr;
    ret_next.mem_rdata = ret_mem_rdata;
    ret_next.mem_wdata = ret_mem_wdata;
    ret_next.mem_rmask = ret_mem_rmask;
    ret_next.mem_wmask = ret_mem_wmask;
`endif
  end

`ifndef VELDT_RVFI_MEM_EN
  // Memory ports stay on the interface so both builds share one pinout.
  logic mem_unused;
  assign mem_unused = ^{ret_mem_addr, ret_mem_rdata, ret_mem_wdata, ret_mem_rmask, ret_mem_wmask};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_FIRST;
      pkt_reg       <= '0;
      valid_reg     <= 1'b0;
      order_reg     <= '0;
      order_cnt_reg <= '0;
      halt_reg      <= 1'b0;
      intr_reg      <= 1'b0;
      intr_pend_reg <= 1'b0;
    end else begin
      valid_reg <= emit;
      if (emit) begin
        pkt_reg       <= ret_next;
        order_reg     <= order_cnt_reg;
        order_cnt_reg <= order_cnt_reg + 64'd1;
        halt_reg      <= halt_req;
        intr_reg      <= intr_pend_reg;
        intr_pend_reg <= ret_trap;
      end
      case (state_reg)
        ST_FIRST:  if (ret_valid) state_reg <= halt_req ? ST_HALTED : ST_RUN;
        ST_RUN:    if (ret_valid && halt_req) state_reg <= ST_HALTED;
        ST_HALTED: state_reg <= ST_HALTED;
        default:   state_reg <= ST_FIRST;
      endcase
    end
  end

  veldt_rvfi_pcchk #(.XLEN(XLEN)) u_pcchk (
    .clock    (clock),
    .reset    (reset),
    .load_en  (emit),
    .check_en (emit && (state_reg == ST_RUN)),
    .pc       (ret_pc),
    .next_pc  (ret_next_pc),
    .pc_gap   (pc_gap)
  );

  assign halted         = (state_reg == ST_HALTED);
  assign rvfi_valid     = valid_reg;
  assign rvfi_order     = order_reg;
  assign rvfi_insn      = pkt_reg.insn;
  assign rvfi_trap      = pkt_reg.trap;
  assign rvfi_halt      = halt_reg;
  assign rvfi_intr      = intr_reg;
  assign rvfi_mode      = RVFI_MODE_M;
  assign rvfi_ixl       = RVFI_IXL_32;
  assign rvfi_rs1_addr  = pkt_reg.rs1_addr;
  assign rvfi_rs2_addr  = pkt_reg.rs2_addr;
  assign rvfi_rs1_rdata = pkt_reg.rs1_data;
  assign rvfi_rs2_rdata = pkt_reg.rs2_data;
  assign rvfi_rd_addr   = pkt_reg.rd_addr;
  assign rvfi_rd_wdata  = pkt_reg.rd_data;
  assign rvfi_pc_rdata  = pkt_reg.pc;
  assign rvfi_pc_wdata  = pkt_reg.next_pc;
  assign rvfi_mem_addr  = pkt_reg.mem_addr;
  assign rvfi_mem_rmask = pkt_reg.mem_rmask;
  assign rvfi_mem_wmask = pkt_reg.mem_wmask;
  assign rvfi_mem_rdata = pkt_reg.mem_rdata;
  assign rvfi_mem_wdata = pkt_reg.mem_wdata;

endmodule
